// File: rtl/bus_ctrl.sv
// bus_ctrl: single-word req/ack memory controller feeding the fetch/decode stage.
// Fetch reads return on cmdOut/cmdPush, data loads on rdData/rdValid, stores are silent.
// Optional feature macro: BUS_TIMEOUT_EN adds an ACCESS wait counter that aborts
// after TIMEOUT_CYCLES cycles without memAck and sets the sticky busErr flag.
module bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  sysMode,
    input  logic        nextRead,
    input  logic        nextWrite,
    input  logic [31:0] pc,
    input  logic [31:0] dataAddr,
    input  logic [31:0] wrData,
    input  logic        errClr,
    output logic [31:0] cmdOut,
    output logic        cmdPush,
    output logic [31:0] rdData,
    output logic        rdValid,
    output logic        busy,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic        memReq,
    output logic        memWe,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        protoErr,
    output logic        busErr
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    state_t state, state_next;
    kind_t  kind, kind_next;

    logic start_store, start_fetch, start_load, start_any;
    logic proto_set, ack_hit, timeout_hit, finish;
    logic [31:0] capture_data;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    // Request decode: a write wins over a simultaneous read; only legal modes start a transfer.
    assign start_store = (state == IDLE) && nextWrite && (sysMode == 2'b01);
    assign start_fetch = (state == IDLE) && nextRead && !nextWrite && (sysMode == 2'b10);
    assign start_load  = (state == IDLE) && nextRead && !nextWrite && (sysMode == 2'b01);
    assign start_any   = start_store || start_fetch || start_load;

    // Any strobe that does not cleanly start a transfer (busy, bad mode, read+write) is a protocol error.
    assign proto_set = (nextRead || nextWrite) && (!start_any || (nextRead && nextWrite));

    assign ack_hit = (state == ACCESS) && memAck;
    assign finish  = ack_hit || timeout_hit;

    // On timeout the read completes with zero, which the decoder treats as a harmless ADD r0.
    assign capture_data = ack_hit ? memRdata : 32'h0;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    assign timeout_hit = (state == ACCESS) && !memAck && (wait_cnt == LAST_WAIT);

    // Wait-cycle counter: restarts at 0 on every entry into ACCESS.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!memAck) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Sticky timeout flag; a new abort in the same cycle as errClr keeps it set.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busErr <= 1'b0;
        end else if (timeout_hit) begin
            busErr <= 1'b1;
        end else if (errClr) begin
            busErr <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign busErr      = 1'b0;
`endif

    // State and transaction-kind registers.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!nrst) begin
            state <= IDLE;
            kind  <= K_FETCH;
        end else begin
            state <= state_next;
            kind  <= kind_next;
        end
    end

    // Next-state logic: IDLE -> ACCESS on a legal strobe, ACCESS -> DONE on ack/abort, DONE -> IDLE.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_next = state;
        kind_next  = kind;
        case (state)
            IDLE: begin
                if (start_store) begin
                    state_next = ACCESS;
                    kind_next  = K_STORE;
                end else if (start_fetch) begin
                    state_next = ACCESS;
                    kind_next  = K_FETCH;
                end else if (start_load) begin
                    state_next = ACCESS;
                    kind_next  = K_LOAD;
                end
            end
            ACCESS:  if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address/data latch on accept, result capture on completion, sticky protocol flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            memAddr  <= '0;
            memWdata <= '0;
            cmdOut   <= '0;
            rdData   <= '0;
            protoErr <= 1'b0;
        end else begin
            if (start_store) begin
                memAddr  <= dataAddr;
                memWdata <= wrData;
            end else if (start_fetch) begin
                memAddr <= pc;
            end else if (start_load) begin
                memAddr <= dataAddr;
            end
            if (finish && kind == K_FETCH) cmdOut <= capture_data;
            if (finish && kind == K_LOAD)  rdData <= capture_data;
            if (proto_set) begin
                protoErr <= 1'b1;
            end else if (errClr) begin
                protoErr <= 1'b0;
            end
        end
    end

    // Handshake outputs decode directly from the registered state, so reset clears them at once.
    assign busy    = (state != IDLE);
    assign memReq  = (state == ACCESS);
    assign memWe   = memReq && (kind == K_STORE);
    assign cmdPush = (state == DONE) && (kind == K_FETCH);
    assign rdValid = (state == DONE) && (kind == K_LOAD);

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: directed-vector bench for bus_ctrl (fetch, store, load, conflict, timeout, reset abort).
module tb_bus_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [1:0]  sysMode = 2'b00;
    logic        nextRead = 1'b0;
    logic        nextWrite = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] dataAddr = '0;
    logic [31:0] wrData = '0;
    logic        errClr = 1'b0;
    logic [31:0] cmdOut;
    logic        cmdPush;
    logic [31:0] rdData;
    logic        rdValid;
    logic        busy;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memReq;
    logic        memWe;
    logic [31:0] memRdata = '0;
    logic        memAck = 1'b0;
    logic        protoErr;
    logic        busErr;

    int vectors = 0;
    int miscompares = 0;
    int push_cnt = 0;
    int rdv_cnt = 0;

    bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .nrst(nrst), .sysMode(sysMode), .nextRead(nextRead), .nextWrite(nextWrite),
        .pc(pc), .dataAddr(dataAddr), .wrData(wrData), .errClr(errClr),
        .cmdOut(cmdOut), .cmdPush(cmdPush), .rdData(rdData), .rdValid(rdValid), .busy(busy),
        .memAddr(memAddr), .memWdata(memWdata), .memReq(memReq), .memWe(memWe),
        .memRdata(memRdata), .memAck(memAck), .protoErr(protoErr), .busErr(busErr)
    );

    always #5 clk = ~clk;

    // Strobe counters sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (cmdPush) push_cnt++;
        if (rdValid) rdv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({memReq, memWe, cmdPush, rdValid, busy, protoErr, busErr} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {memReq, memWe, cmdPush, rdValid, busy, protoErr, busErr});
        end
        vectors++;
        if ({cmdOut, rdData, memAddr, memWdata} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h %h want all zero", cmdOut, rdData, memAddr, memWdata);
        end
        @(negedge clk);
        nrst = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        int p0;
        p0 = push_cnt;
        sysMode = 2'b10; pc = 32'h100; nextRead = 1'b1;
        step();                                  // strobe sampled at edge N
        nextRead = 1'b0;
        vectors++;
        if ({memReq, busy, memWe} !== 3'b110 || memAddr !== 32'h100) begin
            miscompares++;
            $display("FAIL fetch_issue: req/busy/we=%b addr=%h want 110 addr=00000100",
                     {memReq, busy, memWe}, memAddr);
        end
        for (int i = 0; i < 2; i++) begin
            step();                              // edges N+1, N+2 without ack
            vectors++;
            if (memReq !== 1'b1 || cmdPush !== 1'b0) begin
                miscompares++;
                $display("FAIL fetch_wait%0d: req=%b push=%b want req=1 push=0", i, memReq, cmdPush);
            end
        end
        memAck = 1'b1; memRdata = 32'hC9000002;
        step();                                  // ack sampled at N+3
        memAck = 1'b0; memRdata = 32'h0;
        vectors++;
        if (memReq !== 1'b0 || cmdPush !== 1'b1 || busy !== 1'b1 || cmdOut !== 32'hC9000002) begin
            miscompares++;
            $display("FAIL fetch_push: req=%b push=%b busy=%b cmd=%h want 0 1 1 c9000002",
                     memReq, cmdPush, busy, cmdOut);
        end
        step();
        vectors++;
        if (cmdPush !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_end: push=%b busy=%b want 0 0", cmdPush, busy);
        end
        vectors++;
        if (push_cnt - p0 !== 1) begin
            miscompares++;
            $display("FAIL fetch_push_count: got %0d want 1", push_cnt - p0);
        end
    endtask

    task automatic test_store();
        int p0, r0;
        p0 = push_cnt; r0 = rdv_cnt;
        sysMode = 2'b01; dataAddr = 32'h40; wrData = 32'hDEADBEEF; nextWrite = 1'b1;
        step();
        nextWrite = 1'b0;
        vectors++;
        if (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'h40 || memWdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL store_issue: req=%b we=%b addr=%h wd=%h want 1 1 00000040 deadbeef",
                     memReq, memWe, memAddr, memWdata);
        end
        memAck = 1'b1;
        step();
        memAck = 1'b0;
        vectors++;
        if ({memReq, memWe, cmdPush, rdValid} !== 4'b0000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL store_done: req/we/push/rdv=%b busy=%b want 0000 busy=1",
                     {memReq, memWe, cmdPush, rdValid}, busy);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || push_cnt != p0 || rdv_cnt != r0) begin
            miscompares++;
            $display("FAIL store_silent: busy=%b pushes=%0d rdvalids=%0d want 0 0 0",
                     busy, push_cnt - p0, rdv_cnt - r0);
        end
    endtask

    task automatic test_load();
        int r0;
        r0 = rdv_cnt;
        sysMode = 2'b01; dataAddr = 32'h80; nextRead = 1'b1;
        step();
        nextRead = 1'b0;
        vectors++;
        if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h80) begin
            miscompares++;
            $display("FAIL load_issue: req=%b we=%b addr=%h want 1 0 00000080", memReq, memWe, memAddr);
        end
        memAck = 1'b1; memRdata = 32'h12345678;
        step();
        memAck = 1'b0; memRdata = 32'h0;
        vectors++;
        if (rdValid !== 1'b1 || cmdPush !== 1'b0 || rdData !== 32'h12345678 || cmdOut !== 32'hC9000002) begin
            miscompares++;
            $display("FAIL load_data: rdv=%b push=%b rd=%h cmd=%h want 1 0 12345678 c9000002",
                     rdValid, cmdPush, rdData, cmdOut);
        end
        step();
        vectors++;
        if (rdv_cnt - r0 !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_count: rdvalids=%0d busy=%b want 1 0", rdv_cnt - r0, busy);
        end
    endtask

    task automatic test_conflict();
        int p0, r0;
        p0 = push_cnt; r0 = rdv_cnt;
        sysMode = 2'b01; dataAddr = 32'h44; wrData = 32'h55AA; nextRead = 1'b1; nextWrite = 1'b1;
        step();
        nextRead = 1'b0; nextWrite = 1'b0;
        vectors++;
        if (memWe !== 1'b1 || memAddr !== 32'h44 || memWdata !== 32'h55AA || protoErr !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_write: we=%b addr=%h wd=%h perr=%b want 1 00000044 000055aa 1",
                     memWe, memAddr, memWdata, protoErr);
        end
        // Overlapping fetch strobe while busy, together with errClr: the set must win.
        sysMode = 2'b10; pc = 32'h900; nextRead = 1'b1; errClr = 1'b1;
        step();
        nextRead = 1'b0; errClr = 1'b0;
        vectors++;
        if (protoErr !== 1'b1 || memAddr !== 32'h44 || memWe !== 1'b1 || memReq !== 1'b1) begin
            miscompares++;
            $display("FAIL overlap_drop: perr=%b addr=%h we=%b req=%b want 1 00000044 1 1",
                     protoErr, memAddr, memWe, memReq);
        end
        memAck = 1'b1;
        step();
        memAck = 1'b0;
        step();
        step();
        vectors++;
        if (busy !== 1'b0 || protoErr !== 1'b1 || push_cnt != p0 || rdv_cnt != r0) begin
            miscompares++;
            $display("FAIL conflict_after: busy=%b perr=%b pushes=%0d rdvalids=%0d want 0 1 0 0",
                     busy, protoErr, push_cnt - p0, rdv_cnt - r0);
        end
        errClr = 1'b1;
        step();
        errClr = 1'b0;
        vectors++;
        if (protoErr !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: perr=%b want 0", protoErr);
        end
        // Illegal mode 00 strobe is ignored but flagged.
        sysMode = 2'b00; nextRead = 1'b1;
        step();
        nextRead = 1'b0;
        vectors++;
        if (busy !== 1'b0 || memReq !== 1'b0 || protoErr !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_mode: busy=%b req=%b perr=%b want 0 0 1", busy, memReq, protoErr);
        end
        errClr = 1'b1;
        step();
        errClr = 1'b0;
    endtask

    task automatic test_timeout();
        int p0;
        p0 = push_cnt;
        sysMode = 2'b10; pc = 32'h200; nextRead = 1'b1;
        step();
        nextRead = 1'b0;
`ifdef BUS_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if (memReq !== 1'b1 || busErr !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_wait%0d: req=%b berr=%b want 1 0", i, memReq, busErr);
            end
        end
        step();                                  // fourth wait cycle: abort
        vectors++;
        if (memReq !== 1'b0 || busErr !== 1'b1 || cmdPush !== 1'b1 || cmdOut !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_abort: req=%b berr=%b push=%b cmd=%h want 0 1 1 00000000",
                     memReq, busErr, cmdPush, cmdOut);
        end
        step();
        errClr = 1'b1;
        step();
        errClr = 1'b0;
        vectors++;
        if (busErr !== 1'b0 || busy !== 1'b0 || push_cnt - p0 !== 1) begin
            miscompares++;
            $display("FAIL timeout_clear: berr=%b busy=%b pushes=%0d want 0 0 1",
                     busErr, busy, push_cnt - p0);
        end
`else
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (memReq !== 1'b1 || busErr !== 1'b0 || cmdPush !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout_wait: req=%b berr=%b push=%b want 1 0 0", memReq, busErr, cmdPush);
        end
        memAck = 1'b1; memRdata = 32'hA5A5_0001;
        step();
        memAck = 1'b0; memRdata = 32'h0;
        vectors++;
        if (cmdPush !== 1'b1 || cmdOut !== 32'hA5A5_0001 || busErr !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout_done: push=%b cmd=%h berr=%b want 1 a5a50001 0",
                     cmdPush, cmdOut, busErr);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || push_cnt - p0 !== 1) begin
            miscompares++;
            $display("FAIL no_timeout_end: busy=%b pushes=%0d want 0 1", busy, push_cnt - p0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int p0;
        sysMode = 2'b10; pc = 32'h300; nextRead = 1'b1;
        step();
        nextRead = 1'b0;
        step();
        #2;
        nrst = 1'b0;
        #1;
        vectors++;
        if ({memReq, memWe, cmdPush, rdValid, busy, protoErr, busErr} !== 7'b0 ||
            {cmdOut, rdData, memAddr, memWdata} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_mid: ctrl=%b cmd=%h rd=%h addr=%h wd=%h want all zero",
                     {memReq, memWe, cmdPush, rdValid, busy, protoErr, busErr},
                     cmdOut, rdData, memAddr, memWdata);
        end
        p0 = push_cnt;
        @(negedge clk);
        nrst = 1'b1;
        memAck = 1'b1;                           // stray ack with no request must be ignored
        step();
        memAck = 1'b0;
        step();
        step();
        vectors++;
        if (busy !== 1'b0 || memReq !== 1'b0 || push_cnt != p0 || protoErr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b req=%b pushes=%0d perr=%b want 0 0 0 0",
                     busy, memReq, push_cnt - p0, protoErr);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_conflict();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
